// File: rtl/edge_arb_pkg.sv
// ============================================================================
// edge_arb_pkg: shared FSM encodings and index helpers for edge_event_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package edge_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_pulse_cell.sv
// ============================================================================
// edge_pulse_cell: per-channel rising-edge detector with pending and overrun flags
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_pulse_cell
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic enable,
  input  logic accept,
  input  logic clr_overrun,
  output logic pending,
  output logic overrun
);

  logic x_q;
  logic w_set;

  assign w_set = x & ~x_q & enable;

  // x_q resets high so a level held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 1'b1;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      x_q <= x;
      if (w_set)
        pending <= 1'b1;
      else if (accept)
        pending <= 1'b0;
      if (w_set && pending && !accept)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// ============================================================================
// edge_event_arbiter: multi-channel edge event collector, round-robin valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] x,
  input  logic [N_CH-1:0] enable_mask,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CH_W-1:0] ev_ch,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun,
  input  logic            clr_overrun
);

  logic [0:0]      state;
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] winner;
  logic            found;
  logic            accept;

  assign ev_valid = (state == ST_OFFER);
  assign accept   = ev_valid & ev_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic w_acc;
    assign w_acc = accept && (ev_ch == CH_W'(i));

    edge_pulse_cell u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x[i]),
      .enable      (enable_mask[i]),
      .accept      (w_acc),
      .clr_overrun (clr_overrun),
      .pending     (pending[i]),
      .overrun     (overrun[i])
    );
  end

  // Search starts one past the last grant and wraps, so indices stay below N_CH.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = int'(last_grant);
    for (int k = 0; k < N_CH; k++) begin
      idx = rr_next(idx, N_CH);
      if (!found && pending[idx[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ev_ch      <= '0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            ev_ch <= winner;
            state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (ev_ready) begin
            last_grant <= ev_ch;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ============================================================================
// tb_edge_event_arbiter: scoreboard bench for edge_event_arbiter (N_CH = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] enable_mask;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       clr_overrun;

  int total;
  int bad;
  int exp_q[$];

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .enable_mask (enable_mask),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_ch       (ev_ch),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs only move 1 time unit after posedge, so at negedge valid&ready means an accept next edge.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0)
        check("sb_unexpected_event", 32'(ev_ch), 32'hFFFF);
      else
        check("sb_ev_ch", 32'(ev_ch), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    x = 4'b0001;
    enable_mask = 4'hF;
    ev_ready = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_ch", 32'(ev_ch), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Level held high through reset must not create an event.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_high_valid", 32'(ev_valid), 0);
    end
    check("held_high_pending", 32'(pending), 0);
    x = 4'b0000;
    tick();
    x = 4'b0001;
    exp_q.push_back(0);
    tick();
    check("lat_e0_pending", 32'(pending), 32'h1);
    check("lat_e0_valid", 32'(ev_valid), 0);
    tick();
    check("lat_e1_valid", 32'(ev_valid), 1);
    check("lat_e1_ch", 32'(ev_ch), 0);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("acc0_valid", 32'(ev_valid), 0);
    check("acc0_pending", 32'(pending), 0);

    // Channels 1 and 3 rise together with ready tied high.
    x = 4'b1011;
    ev_ready = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(3);
    tick();
    tick();
    check("pair_first_valid", 32'(ev_valid), 1);
    check("pair_first_ch", 32'(ev_ch), 1);
    tick();
    check("pair_bubble", 32'(ev_valid), 0);
    tick();
    check("pair_second_valid", 32'(ev_valid), 1);
    check("pair_second_ch", 32'(ev_ch), 3);
    tick();
    check("pair_done_valid", 32'(ev_valid), 0);
    check("pair_done_pending", 32'(pending), 0);
    ev_ready = 1'b0;

    // Stall on ch2 while ch0 rises; no re-arbitration, then round-robin to ch0.
    x = 4'b0000;
    tick();
    x = 4'b0100;
    exp_q.push_back(2);
    tick();
    tick();
    check("stall_ch", 32'(ev_ch), 2);
    x = 4'b0101;
    exp_q.push_back(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_valid", 32'(ev_valid), 1);
      check("stall_hold_ch", 32'(ev_ch), 2);
    end
    check("stall_pending", 32'(pending), 32'h5);
    ev_ready = 1'b1;
    tick();
    check("stall_bubble", 32'(ev_valid), 0);
    tick();
    check("rr_next_valid", 32'(ev_valid), 1);
    check("rr_next_ch", 32'(ev_ch), 0);
    tick();
    ev_ready = 1'b0;
    check("rr_done_pending", 32'(pending), 0);

    // Two extra rises on ch1 before accept -> sticky overrun, one delivery.
    x = 4'b0000;
    tick();
    x = 4'b0010;
    exp_q.push_back(1);
    tick();
    for (int i = 0; i < 2; i++) begin
      x = 4'b0000;
      tick();
      x = 4'b0010;
      tick();
    end
    check("ovr_set", 32'(overrun), 32'h2);
    check("ovr_pending", 32'(pending), 32'h2);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovr_single_delivery", 32'(ev_valid), 0);
    end
    check("ovr_sticky", 32'(overrun), 32'h2);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    // Rise on ch2 in the very cycle ch2 is accepted: set wins, no overrun.
    x = 4'b0000;
    tick();
    x = 4'b0100;
    exp_q.push_back(2);
    tick();
    tick();
    check("sw_offer_ch", 32'(ev_ch), 2);
    x = 4'b0000;
    tick();
    x = 4'b0100;
    ev_ready = 1'b1;
    exp_q.push_back(2);
    tick();
    ev_ready = 1'b0;
    check("sw_pending", 32'(pending), 32'h4);
    check("sw_overrun", 32'(overrun), 0);
    tick();
    check("sw_reoffer_valid", 32'(ev_valid), 1);
    check("sw_reoffer_ch", 32'(ev_ch), 2);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("sw_done_pending", 32'(pending), 0);

    // Masked channel 0 raises nothing.
    enable_mask = 4'b1110;
    x = 4'b0000;
    tick();
    x = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mask_valid", 32'(ev_valid), 0);
    end
    check("mask_pending", 32'(pending), 0);

    // Reset in the middle of an offer clears everything without a clock edge.
    enable_mask = 4'hF;
    x = 4'b0000;
    tick();
    x = 4'b1000;
    tick();
    tick();
    check("mid_offer_valid", 32'(ev_valid), 1);
    x = 4'b0000;
    tick();
    x = 4'b1010;
    tick();
    check("mid_overrun", 32'(overrun), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ev_valid), 0);
    check("async_rst_pending", 32'(pending), 0);
    check("async_rst_overrun", 32'(overrun), 0);
    tick();
    check("sb_leftover", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
